// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: in-order imem fetch, prefetch queue, redirect drop.
// Optional FETCH_PERF_EN adds saturating bubble/redirect/drop counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic [1:0]  PC_Src_E,
  input  logic [31:0] PCTarget_E,
  input  logic [31:0] ALUResult_E,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] QD = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_f;
  logic [31:0]   target;
  logic          redirect;
  logic          accept;
  logic          push;
  logic          pop;
  logic          room;
  logic [CW-1:0] q_cnt;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [AW-1:0] a_rd;
  logic [AW-1:0] a_wr;
  logic [31:0]   q_pc  [QUEUE_DEPTH];
  logic [31:0]   q_ins [QUEUE_DEPTH];
  logic [31:0]   a_pc  [QUEUE_DEPTH];

  // PC_Src_E == 11 is reserved and behaves as sequential fetch
  always_comb begin
    redirect = 1'b0;
    target   = pc_f;
    unique case (1'b1)
      PC_Src_E == 2'b01: begin
        redirect = 1'b1;
        target   = PCTarget_E;
      end
      PC_Src_E == 2'b10: begin
        redirect = 1'b1;
        target   = {ALUResult_E[31:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign room = ({1'b0, q_cnt} + {1'b0, outst}) < QD;
  assign imem_req_valid = !reset && !Stall_F && !redirect && room;
  assign imem_req_addr  = pc_f;
  assign accept = imem_req_valid && imem_req_ready;
  assign push   = imem_rsp_valid && !redirect && (drop == '0);
  assign pop    = !Flush_D && !Stall_D && (q_cnt != '0);

  // Address FIFO tracks every outstanding request, stale ones included
  always_ff @(posedge clk) begin
    if (accept)
      a_pc[a_wr] <= pc_f;
    if (push) begin
      q_pc[q_wr]  <= a_pc[a_rd];
      q_ins[q_wr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f      <= RESET_PC;
      q_cnt     <= '0;
      outst     <= '0;
      drop      <= '0;
      q_rd      <= '0;
      q_wr      <= '0;
      a_rd      <= '0;
      a_wr      <= '0;
      Instr_D   <= NOP;
      PC_D      <= 32'h0;
      PCPlus4_D <= 32'h4;
      Valid_D   <= 1'b0;
    end else begin
      if (redirect)
        pc_f <= target;
      else if (accept)
        pc_f <= pc_f + 32'd4;
      if (accept)
        a_wr <= a_wr + AW'(1);
      if (imem_rsp_valid)
        a_rd <= a_rd + AW'(1);
      outst <= outst + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect)
        drop <= outst - CW'(imem_rsp_valid);
      else if (imem_rsp_valid && drop != '0)
        drop <= drop - CW'(1);
      if (redirect) begin
        q_cnt <= '0;
        q_rd  <= '0;
        q_wr  <= '0;
      end else begin
        if (push)
          q_wr <= q_wr + AW'(1);
        if (pop)
          q_rd <= q_rd + AW'(1);
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
      end
      if (Flush_D) begin
        Instr_D <= NOP;
        Valid_D <= 1'b0;
      end else if (!Stall_D) begin
        if (q_cnt != '0) begin
          Instr_D   <= q_ins[q_rd];
          PC_D      <= q_pc[q_rd];
          PCPlus4_D <= q_pc[q_rd] + 32'd4;
          Valid_D   <= 1'b1;
        end else begin
          Instr_D <= NOP;
          Valid_D <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_bubble_cnt   <= '0;
      perf_redirect_cnt <= '0;
      perf_drop_cnt     <= '0;
    end else begin
      if (!Stall_D && !Flush_D && q_cnt == '0 && perf_bubble_cnt != '1)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (redirect && perf_redirect_cnt != '1)
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      if (imem_rsp_valid && (redirect || drop != '0) && perf_drop_cnt != '1)
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule
